// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Decodes an ALU operation and holds it in a single-entry
//                ID/EX register with ready/valid handshaking, flush support
//                and a saturating count of illegal operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_b5,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [3:0]        control,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [3:0] c_CTL_ADD = 4'b0010;
    localparam logic [3:0] c_CTL_SUB = 4'b0110;
    localparam logic [3:0] c_CTL_AND = 4'b0000;
    localparam logic [3:0] c_CTL_OR  = 4'b0001;
    localparam logic [3:0] c_CTL_ILL = 4'b1111;

    localparam logic [1:0] c_OP_MEM  = 2'b00;
    localparam logic [1:0] c_OP_BR   = 2'b01;
    localparam logic [1:0] c_OP_RTY  = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic              r_valid;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [3:0]        r_control;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_illegal_cnt;

    logic [3:0]        w_control;
    logic              w_illegal;
    logic [DATA_W-1:0] w_data2;
    logic              w_accept;

    always_comb begin
        w_control = c_CTL_ILL;
        case (alu_op)
            c_OP_MEM: w_control = c_CTL_ADD;
            c_OP_BR:  w_control = c_CTL_SUB;
            c_OP_RTY: begin
                case (funct3)
                    3'b000:  w_control = funct7_b5 ? c_CTL_SUB : c_CTL_ADD;
                    3'b111:  w_control = c_CTL_AND;
                    3'b110:  w_control = c_CTL_OR;
                    default: w_control = c_CTL_ILL;
                endcase
            end
            default: begin
                // I-type has no subtract form, so funct7_b5 is ignored here
                case (funct3)
                    3'b000:  w_control = c_CTL_ADD;
                    3'b111:  w_control = c_CTL_AND;
                    3'b110:  w_control = c_CTL_OR;
                    default: w_control = c_CTL_ILL;
                endcase
            end
        endcase
    end

    assign w_illegal = (w_control == c_CTL_ILL);
    assign w_data2   = (alu_op == c_OP_BR || alu_op == c_OP_RTY) ? rs2_data : imm;
    assign in_ready  = ~r_valid | out_ready;
    assign w_accept  = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_data1       <= '0;
            r_data2       <= '0;
            r_control     <= c_CTL_ADD;
            r_illegal     <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end

            if (w_accept) begin
                r_data1   <= rs1_data;
                r_data2   <= w_data2;
                r_control <= w_control;
                r_illegal <= w_illegal;
                if (w_illegal && r_illegal_cnt != c_CNT_MAX) begin
                    r_illegal_cnt <= r_illegal_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_valid;
    assign data1       = r_data1;
    assign data2       = r_data2;
    assign control     = r_control;
    assign illegal     = r_illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: DATA_W, 32, operand width in bits.
REQ-002 Parameter: CNT_W, 8, width of the illegal-operation counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  upstream (ID) holds a valid operation.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 alu_op  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7_b5  input  1  instruction bit 30.
REQ-010 rs1_data  input  DATA_W  first operand.
REQ-011 rs2_data  input  DATA_W  second register operand.
REQ-012 imm  input  DATA_W  sign-extended immediate.
REQ-013 flush  input  1  discard held and incoming operation (branch redirect).
REQ-014 out_valid  output  1  data1/data2/control hold a valid operation for EX.
REQ-015 out_ready  input  1  EX consumes the operation this cycle.
REQ-016 data1  output  DATA_W  registered ALU operand 1.
REQ-017 data2  output  DATA_W  registered ALU operand 2.
REQ-018 control  output  4  registered ALU control code.
REQ-019 illegal  output  1  registered; held operation had no legal ALU encoding.
REQ-020 illegal_cnt  output  CNT_W  count of illegal operations accepted.

Function
REQ-021 Control codes SHALL be ADD 0010, SUB 0110, AND 0000, OR 0001, ILLEGAL 1111.
REQ-022 alu_op 00 SHALL decode to ADD; alu_op 01 to SUB, regardless of funct fields.
REQ-023 alu_op 10 SHALL decode funct3 000 with funct7_b5 0 to ADD, with funct7_b5 1 to SUB, 111 to AND, 110 to OR, all else ILLEGAL.
REQ-024 alu_op 11 SHALL decode funct3 000 to ADD (funct7_b5 ignored), 111 to AND, 110 to OR, all else ILLEGAL.
REQ-025 data2 SHALL capture rs2_data for alu_op 01 and 10, imm for alu_op 00 and 11; data1 SHALL capture rs1_data.
REQ-026 illegal SHALL be 1 exactly when the captured control is ILLEGAL.
REQ-027 Stage SHALL be a single-entry pipeline register: accept when in_valid and in_ready; latency one cycle from acceptance to out_valid.
REQ-028 in_ready SHALL equal (not out_valid) or out_ready (combinational pass-through of downstream ready).
REQ-029 Simultaneous consume and accept SHALL replace the held entry with the new one, out_valid remaining 1 (no bubble).
REQ-030 While out_valid and not out_ready, data1, data2, control, illegal SHALL hold stable.
REQ-031 flush SHALL clear out_valid next cycle and SHALL block acceptance that cycle, overriding in_valid and out_ready.
REQ-032 illegal_cnt SHALL increment by 1 on each accepted ILLEGAL operation, saturating at all-ones; flushed-cycle inputs SHALL not count.
REQ-033 Operand/control registers SHALL load only on acceptance; out_valid 0 outputs are don't-care except reset values.

Reset
REQ-034 Asserting rst_n low SHALL immediately force out_valid 0, data1 0, data2 0, control 0010, illegal 0, illegal_cnt 0, irrespective of clk.
REQ-035 Reset mid-operation SHALL discard the held entry; first acceptance allowed on the first rising edge after rst_n returns high.

Verification
REQ-036 Reset, then alu_op 10, funct3 000, funct7_b5 1, rs1 9, rs2 4, out_ready 1 -> next cycle out_valid 1, control 0110, data1 9, data2 4.
REQ-037 alu_op 11, funct3 000, funct7_b5 1, imm 0xFFFFFFFF -> control 0010, data2 0xFFFFFFFF, illegal 0.
REQ-038 Held entry with out_ready 0 for 3 cycles while in_valid 1 -> in_ready 0, outputs unchanged; out_ready 1 -> new entry next cycle, no bubble.
REQ-039 flush asserted with in_valid 1 and held entry -> next cycle out_valid 0, illegal_cnt unchanged.
REQ-040 256 accepted alu_op 10 funct3 001 ops -> control 1111, illegal 1, illegal_cnt saturates at 255.
REQ-041 rst_n low between clock edges with out_valid 1 -> out_valid 0 and control 0010 before next edge.
